dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory (256 x 8, synchronous write, combinational read) between the core load/store unit (requester 0) and the program/data loader engine (requester 1).
- Zero-latency grant with round-robin fairness.
- Optional lock lets one requester hold the port for a bounded burst.
- Sits between both requesters and the memory port; drives the memory write enable, address and write data.

Parameters:
- W, 8, data and address width; must match the data memory.
- MAX_BURST, 4, maximum consecutive locked grants while the other requester waits; range 1..15.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- r0_req  input  1  requester 0 access request
- r0_we  input  1  requester 0 write (1) / read (0)
- r0_lock  input  1  requester 0 asks to keep ownership next cycle
- r0_addr  input  W  requester 0 address
- r0_wdata  input  W  requester 0 write data
- r0_gnt  output  1  requester 0 granted this cycle
- r0_rdata  output  W  read data to requester 0
- r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rdata: same as requester 0
- mem_we  output  1  to data memory WriteEn
- mem_addr  output  W  to data memory DataAddress
- mem_wdata  output  W  to data memory DataIn
- mem_rdata  input  W  from data memory DataOut

Behaviour:
- State registers:
  - owner: IDLE / OWN0 / OWN1
  - last: id of the last granted requester, 1 bit
  - burst_cnt: 4 bits, saturating at MAX_BURST
- Reset values: owner=IDLE, last=1 (requester 0 wins the first tie), burst_cnt=0.
  - While reset=1: r0_gnt=r1_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, r0_rdata=r1_rdata=0.
- Grant is combinational from the current reqs plus the registered state, evaluated in priority order:
  1. owner=OWNx, rx_req=1, and (other req=0 or burst_cnt<MAX_BURST) -> grant x.
  2. Exactly one req -> grant it.
  3. Both reqs -> grant !last.
  4. No req -> no grant.
- At most one grant per cycle; r0_gnt & r1_gnt never both 1.
- Memory drive:
  - Granted requester's addr/wdata drive mem_addr/mem_wdata.
  - mem_we = gnt & that requester's we.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Read latency 0: rx_rdata = mem_rdata while rx_gnt=1, else 0.
  - A write commits at the clock edge ending the grant cycle.
  - A read in the next cycle at the same address returns the new value.
- Requester contract: a request not granted must be held unchanged (req, we, addr, wdata) until granted. The arbiter does not buffer.
- State update at posedge, when not in reset:
  - Any grant to x: last<=x.
  - Granted x with rx_lock=1:
    - If owner was OWNx: burst_cnt<=min(burst_cnt+1, MAX_BURST).
    - Else: burst_cnt<=1.
    - owner<=OWNx.
  - Granted x with rx_lock=0: owner<=IDLE, burst_cnt<=0.
  - No grant: owner<=IDLE, burst_cnt<=0. A locked owner that drops req loses ownership.
- Burst limit:
  - Once burst_cnt==MAX_BURST and the other requester is waiting, rule 1 fails and rule 3 grants the other requester (last==owner).
  - Ownership then passes to the other requester if it locks, else goes to IDLE.
  - With no competitor, the owner keeps the port indefinitely; burst_cnt holds at MAX_BURST.
- Lock asserted by a non-granted requester is ignored.
- Reset mid-burst:
  - Ownership and counter are cleared.
  - A write presented in the reset cycle is not committed; mem_we is forced 0.

Test Plan:
- Reset, then r0 and r1 both request reads of addr 0x10 / 0x20 -> cycle1 r0_gnt=1, mem_addr=0x10; cycle2 r1_gnt=1, mem_addr=0x20; cycles alternate thereafter.
- r0 writes 0xA5 to 0x33 alone; next cycle r1 reads 0x33 -> r1_rdata=0xA5, mem_we=1 only in the first cycle.
- r0 holds req+lock, r1 requests from cycle 0, MAX_BURST=4 -> r0 granted cycles 0-3, r1 granted cycle 4; r0 granted again in cycle 5 if still requesting.
- r1 holds req+lock for 10 cycles, r0 idle -> r1_gnt=1 every cycle, burst_cnt saturates at 4, r0_gnt never 1.
- r0 locked owner drops req for 1 cycle while r1 idle -> owner=IDLE; next simultaneous request is granted to r1 (last=0).
- Reset asserted during an r0 locked write burst to 0x40 -> mem_we=0 that cycle, all grants 0; after release both requesting -> r0 granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory (256 x 8, synchronous write,
// combinational read) between the core load/store unit (requester 0) and the
// program/data loader engine (requester 1).
//
// Grants are combinational (zero latency) from the current requests and the
// registered arbitration state. Ties are broken round-robin. A granted
// requester may assert its lock to keep the port on the following cycle, for
// at most MAX_BURST consecutive locked grants while the other side waits.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   r0_* / r1_*           requester interfaces:
//     *_req               access request
//     *_we                write (1) / read (0)
//     *_lock              keep ownership next cycle
//     *_addr, *_wdata     address and write data
//     *_gnt               granted this cycle
//     *_rdata             read data (valid while granted, else 0)
//   mem_we, mem_addr,
//   mem_wdata             drive the memory WriteEn / DataAddress / DataIn
//   mem_rdata             memory DataOut (combinational)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         r0_req,
  input  logic         r0_we,
  input  logic         r0_lock,
  input  logic [W-1:0] r0_addr,
  input  logic [W-1:0] r0_wdata,
  output logic         r0_gnt,
  output logic [W-1:0] r0_rdata,
  input  logic         r1_req,
  input  logic         r1_we,
  input  logic         r1_lock,
  input  logic [W-1:0] r1_addr,
  input  logic [W-1:0] r1_wdata,
  output logic         r1_gnt,
  output logic [W-1:0] r1_rdata,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  logic [1:0] owner_reg, owner_next;
  logic       last_reg, last_next;
  logic [3:0] burst_cnt_reg, burst_cnt_next;

  logic       gnt0;
  logic       gnt1;
  logic       below_limit;
  logic       any_gnt;
  logic       sel_lock;
  logic       sel_id;
  logic [1:0] sel_own;

  // -------------------------------------------------------------------------
  // Grant decision, in priority order: sticky owner (unless its burst is
  // exhausted and the other side is waiting), lone requester, round-robin.
  // -------------------------------------------------------------------------
  always_comb begin
    below_limit = (burst_cnt_reg < MAX_CNT);
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (owner_reg == OWN0 && r0_req && (!r1_req || below_limit)) begin
      gnt0 = 1'b1;
    end else if (owner_reg == OWN1 && r1_req && (!r0_req || below_limit)) begin
      gnt1 = 1'b1;
    end else if (r0_req && !r1_req) begin
      gnt0 = 1'b1;
    end else if (r1_req && !r0_req) begin
      gnt1 = 1'b1;
    end else if (r0_req && r1_req) begin
      // Whoever was served last yields. After an exhausted burst the owner is
      // also the last grantee, so this hands the port to the waiting side.
      if (last_reg) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;

  // -------------------------------------------------------------------------
  // Memory port mux. Idle port is driven to all zeros so nothing stray is
  // written and the address bus stays quiet.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = r0_we;
      mem_addr  = r0_addr;
      mem_wdata = r0_wdata;
    end else if (gnt1) begin
      mem_we    = r1_we;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  // Read data is steered only to the granted requester.
  assign r0_rdata = gnt0 ? mem_rdata : '0;
  assign r1_rdata = gnt1 ? mem_rdata : '0;

  // -------------------------------------------------------------------------
  // Next arbitration state
  // -------------------------------------------------------------------------
  always_comb begin
    any_gnt  = gnt0 | gnt1;
    sel_id   = gnt1;
    sel_lock = gnt0 ? r0_lock : r1_lock;
    sel_own  = gnt0 ? OWN0 : OWN1;

    owner_next     = IDLE;
    last_next      = last_reg;
    burst_cnt_next = 4'd0;

    if (any_gnt) begin
      last_next = sel_id;
      if (sel_lock) begin
        owner_next = sel_own;
        if (owner_reg == sel_own) begin
          // Continuing burst: count up, saturating at the limit so a lone
          // owner can keep the port indefinitely.
          burst_cnt_next = (burst_cnt_reg >= MAX_CNT) ? MAX_CNT
                                                      : burst_cnt_reg + 4'd1;
        end else begin
          burst_cnt_next = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg     <= IDLE;
      last_reg      <= 1'b1;   // requester 0 wins the first tie
      burst_cnt_reg <= 4'd0;
    end else begin
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed scenarios followed by constrained-random traffic. A 256 x 8 memory
// model hangs off the arbiter's memory port; a behavioural reference model
// (holder / run length / last winner plus its own copy of memory contents)
// predicts every grant, memory drive and read-data value.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int W         = 8;
  localparam int MAX_BURST = 4;

  logic         clk;
  logic         reset;
  logic         r0_req, r0_we, r0_lock;
  logic [W-1:0] r0_addr, r0_wdata;
  logic         r0_gnt;
  logic [W-1:0] r0_rdata;
  logic         r1_req, r1_we, r1_lock;
  logic [W-1:0] r1_addr, r1_wdata;
  logic         r1_gnt;
  logic [W-1:0] r1_rdata;
  logic         mem_we;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.W(W), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .reset     (reset),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_lock   (r0_lock),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rdata  (r0_rdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_lock   (r1_lock),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rdata  (r1_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory attached to the arbiter
  logic [7:0] tb_mem [256];
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
  end

  // Reference model state
  logic [7:0] ref_mem [256];
  int m_holder;   // -1 nobody, else requester id holding a lock
  int m_run;      // consecutive locked grants of the holder
  int m_last;     // last winner

  int errors;
  int checks;

  // Observations of the most recent cycle, for directed checks
  logic       obs_g0, obs_g1, obs_we;
  logic [7:0] obs_addr, obs_r0d, obs_r1d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    bit q0, q1;
    q0 = r0_req;
    q1 = r1_req;
    if (m_holder == 0 && q0 && (!q1 || m_run < MAX_BURST)) return 0;
    if (m_holder == 1 && q1 && (!q0 || m_run < MAX_BURST)) return 1;
    if (q0 && !q1) return 0;
    if (q1 && !q0) return 1;
    if (q0 && q1) return 1 - m_last;
    return -1;
  endfunction

  // Check one cycle against the model, advance the model, run the clock edge.
  // Entered and left just after a falling edge with inputs already driven.
  task automatic tick(input string tag);
    int         w;
    logic       e_we, w_lock;
    logic [7:0] e_addr, e_wdata, e_rd;
    #1;
    w       = reset ? -1 : pick();
    e_we    = 1'b0;
    e_addr  = 8'h00;
    e_wdata = 8'h00;
    w_lock  = 1'b0;
    if (w == 0) begin
      e_we = r0_we; e_addr = r0_addr; e_wdata = r0_wdata; w_lock = r0_lock;
    end else if (w == 1) begin
      e_we = r1_we; e_addr = r1_addr; e_wdata = r1_wdata; w_lock = r1_lock;
    end
    e_rd = (w >= 0) ? ref_mem[e_addr] : 8'h00;

    obs_g0 = r0_gnt; obs_g1 = r1_gnt; obs_we = mem_we;
    obs_addr = mem_addr; obs_r0d = r0_rdata; obs_r1d = r1_rdata;

    chk({tag, ".r0_gnt"},    32'(r0_gnt),    32'(w == 0));
    chk({tag, ".r1_gnt"},    32'(r1_gnt),    32'(w == 1));
    chk({tag, ".mem_we"},    32'(mem_we),    32'(e_we));
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'(e_addr));
    chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(e_wdata));
    chk({tag, ".r0_rdata"},  32'(r0_rdata),  32'((w == 0) ? e_rd : 8'h00));
    chk({tag, ".r1_rdata"},  32'(r1_rdata),  32'((w == 1) ? e_rd : 8'h00));

    $display("%s: rst=%0b req=%0b%0b win=%0d we=%0b addr=%02h wdata=%02h rd=%02h",
             tag, reset, r1_req, r0_req, w, mem_we, mem_addr, mem_wdata, e_rd);

    if (reset) begin
      m_holder = -1; m_run = 0; m_last = 1;
    end else if (w >= 0) begin
      if (w_lock) begin
        m_run    = (m_holder == w) ? ((m_run + 1 > MAX_BURST) ? MAX_BURST : m_run + 1) : 1;
        m_holder = w;
      end else begin
        m_holder = -1; m_run = 0;
      end
      m_last = w;
      if (e_we) ref_mem[e_addr] = e_wdata;
    end else begin
      m_holder = -1; m_run = 0;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv0(input logic req, input logic we, input logic lock,
                      input logic [7:0] addr, input logic [7:0] wdata);
    r0_req = req; r0_we = we; r0_lock = lock; r0_addr = addr; r0_wdata = wdata;
  endtask

  task automatic drv1(input logic req, input logic we, input logic lock,
                      input logic [7:0] addr, input logic [7:0] wdata);
    r1_req = req; r1_we = we; r1_lock = lock; r1_addr = addr; r1_wdata = wdata;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_holder = -1; m_run = 0; m_last = 1;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'(i ^ 8'h5A);
      ref_mem[i] = 8'(i ^ 8'h5A);
    end
    reset = 1'b1;
    drv0(1'b1, 1'b1, 1'b1, 8'h11, 8'hEE);
    drv1(1'b1, 1'b1, 1'b0, 8'h12, 8'hDD);
    @(negedge clk);

    // Reset with live requests: everything quiet, nothing written
    tick("rst0");
    tick("rst1");
    chk("rst.no_gnt", 32'({obs_g0, obs_g1, obs_we}), 32'd0);
    reset = 1'b0;

    // Both read: r0 first, then strict alternation
    drv0(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    drv1(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
    tick("alt1");
    chk("alt1.r0_first", 32'({obs_g0, obs_addr}), 32'({1'b1, 8'h10}));
    tick("alt2");
    chk("alt2.r1_next", 32'({obs_g1, obs_addr}), 32'({1'b1, 8'h20}));
    tick("alt3");
    chk("alt3.r0_again", 32'(obs_g0), 32'd1);
    tick("alt4");
    chk("alt4.r1_again", 32'(obs_g1), 32'd1);

    // Write then read-back by the other requester
    drv0(1'b1, 1'b1, 1'b0, 8'h33, 8'hA5);
    drv1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick("wr33");
    chk("wr33.we", 32'(obs_we), 32'd1);
    drv0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drv1(1'b1, 1'b0, 1'b0, 8'h33, 8'h00);
    tick("rd33");
    chk("rd33.data", 32'(obs_r1d), 32'hA5);
    chk("rd33.we", 32'(obs_we), 32'd0);

    // r0 locked burst against waiting r1: r0 x4, r1, r0
    drv0(1'b1, 1'b0, 1'b1, 8'h01, 8'h00);
    drv1(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
    for (int c = 0; c < 4; c++) begin
      tick($sformatf("burst%0d", c));
      chk($sformatf("burst%0d.r0", c), 32'(obs_g0), 32'd1);
    end
    tick("burst4");
    chk("burst4.r1", 32'(obs_g1), 32'd1);
    drv1(1'b1, 1'b0, 1'b0, 8'h03, 8'h00);
    tick("burst5");
    chk("burst5.r0", 32'(obs_g0), 32'd1);

    // r1 alone and locked for 10 cycles: never interrupted
    drv0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drv1(1'b1, 1'b1, 1'b1, 8'h50, 8'h00);
    for (int c = 0; c < 10; c++) begin
      r1_addr = 8'(8'h50 + c);
      r1_wdata = 8'(8'hC0 + c);
      tick($sformatf("solo%0d", c));
      chk($sformatf("solo%0d.gnt", c), 32'({obs_g1, obs_g0}), 32'b10);
    end

    // r0 locked owner drops req for one cycle -> loses ownership, last=0
    drv1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drv0(1'b1, 1'b0, 1'b1, 8'h55, 8'h00);
    tick("drop0");
    tick("drop1");
    drv0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick("drop2");
    drv0(1'b1, 1'b0, 1'b0, 8'h56, 8'h00);
    drv1(1'b1, 1'b0, 1'b0, 8'h57, 8'h00);
    tick("drop3");
    chk("drop3.r1_wins", 32'(obs_g1), 32'd1);

    // Reset in the middle of an r0 locked write burst to 0x40
    drv1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drv0(1'b1, 1'b1, 1'b1, 8'h40, 8'h77);
    tick("rb0");
    tick("rb1");
    r0_wdata = 8'h99;
    reset = 1'b1;
    tick("rb_rst");
    chk("rb_rst.quiet", 32'({obs_g0, obs_g1, obs_we}), 32'd0);
    reset = 1'b0;
    drv0(1'b1, 1'b0, 1'b0, 8'h40, 8'h00);
    drv1(1'b1, 1'b0, 1'b0, 8'h41, 8'h00);
    tick("rb_after");
    chk("rb_after.r0_first", 32'(obs_g0), 32'd1);
    chk("rb_after.data", 32'(obs_r0d), 32'h77);

    // Random traffic honouring the hold-until-granted contract
    for (int c = 0; c < 400; c++) begin
      if (!(r0_req && !obs_g0) || reset) begin
        drv0(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'b0,
             8'($urandom_range(0, 15)), 8'($urandom));
      end
      if (!(r1_req && !obs_g1) || reset) begin
        drv1(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'b0,
             8'($urandom_range(0, 15)), 8'($urandom));
      end
      r0_lock = 1'($urandom_range(0, 3) != 0);
      r1_lock = 1'($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 59) == 0);
      tick($sformatf("rnd%0d", c));
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
